// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Registered VGA test-pattern source. Takes the free-running column/row
// counts from the VGA counter and produces 3-channel video from one of
// eight patterns. The select input comes from switches, so it passes
// through a two-flop synchroniser. The active pattern, the frame counter
// and the moving-bar position change only at pixel (0,0), so a frame never
// tears. Video, the delayed counts and the frame-start pulse leave together,
// exactly one clock after the counts arrive.

module vga_pattern_gen #(
    parameter int c_VIDEO_WIDTH = 3,
    parameter int c_ACTIVE_COLS = 640,
    parameter int c_ACTIVE_ROWS = 480,
    parameter int c_BAR_WIDTH   = 80,
    parameter int c_CHECK_BIT   = 5,
    parameter int c_MOVE_WIDTH  = 16,
    parameter int c_MOVE_STEP   = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic [9:0]               i_Col_Count,
    input  logic [9:0]               i_Row_Count,
    input  logic [2:0]               i_Pattern_Sel,
    output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic [9:0]               o_Col_Count,
    output logic [9:0]               o_Row_Count,
    output logic                     o_Frame_Start
);

    // One bit of headroom above the 10-bit counts keeps sums such as
    // pos + step and pos + width from overflowing before they are compared.
    localparam logic [10:0] ACT_COLS  = 11'(c_ACTIVE_COLS);
    localparam logic [10:0] ACT_ROWS  = 11'(c_ACTIVE_ROWS);
    localparam logic [10:0] BAR_W     = 11'(c_BAR_WIDTH);
    localparam logic [10:0] MOVE_W    = 11'(c_MOVE_WIDTH);
    localparam logic [10:0] MOVE_STEP = 11'(c_MOVE_STEP);

    // Synchroniser for the switch inputs.
    logic [2:0]  sel_meta;
    logic [2:0]  sel_sync;

    // Per-frame state and the values that apply to the current pixel.
    logic [2:0]  pattern;
    logic [2:0]  pattern_eff;
    logic [7:0]  frame_cnt;
    logic [7:0]  frame_cnt_eff;
    logic [9:0]  bar_pos;
    logic [9:0]  bar_pos_eff;
    logic [10:0] pos_sum;
    logic [10:0] pos_wrapped;
    logic        frame_start;

    // Pixel geometry.
    logic [10:0] col_x;
    logic [10:0] row_x;
    logic        active;
    logic [2:0]  bar_idx;
    logic [2:0]  bar_rgb;
    logic        checker_on;
    logic        border_on;
    logic        move_on;
    logic [10:0] move_start;
    logic [10:0] move_end;

    // Combinational video before the output register.
    logic [c_VIDEO_WIDTH-1:0] red_next;
    logic [c_VIDEO_WIDTH-1:0] grn_next;
    logic [c_VIDEO_WIDTH-1:0] blu_next;

    assign col_x = {1'b0, i_Col_Count};
    assign row_x = {1'b0, i_Row_Count};

    // Two-flop synchroniser bringing the switch select into the pixel clock domain.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sel_meta <= 3'd0;
            sel_sync <= 3'd0;
        end else begin
            sel_meta <= i_Pattern_Sel;
            sel_sync <= sel_meta;
        end
    end

    // Frame-boundary detection and the per-frame values the current pixel uses.
    // At (0,0) the freshly updated values are used straight away, so the new
    // pattern starts exactly at the first pixel of the frame.
    always_comb begin
        frame_start = (i_Col_Count == 10'd0) && (i_Row_Count == 10'd0);
        pos_sum     = {1'b0, bar_pos} + MOVE_STEP;
        if (pos_sum >= ACT_COLS) begin
            pos_wrapped = pos_sum - ACT_COLS;
        end else begin
            pos_wrapped = pos_sum;
        end
        if (frame_start) begin
            pattern_eff   = sel_sync;
            frame_cnt_eff = frame_cnt + 8'd1;
            bar_pos_eff   = pos_wrapped[9:0];
        end else begin
            pattern_eff   = pattern;
            frame_cnt_eff = frame_cnt;
            bar_pos_eff   = bar_pos;
        end
    end

    // Per-frame state register: active pattern, frame counter, bar position.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            pattern   <= 3'd0;
            frame_cnt <= 8'd0;
            bar_pos   <= 10'd0;
        end else begin
            pattern   <= pattern_eff;
            frame_cnt <= frame_cnt_eff;
            bar_pos   <= bar_pos_eff;
        end
    end

    // Bar index as a comparator chain: count how many bar edges lie at or left of the column.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (col_x >= 11'(k) * BAR_W) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    // Colour-bar lookup as {red, green, blue} on/off: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    // Geometric tests shared by the patterns: visible area, checker, border, moving bar.
    always_comb begin
        active     = (col_x < ACT_COLS) && (row_x < ACT_ROWS);
        checker_on = i_Col_Count[c_CHECK_BIT] ^ i_Row_Count[c_CHECK_BIT];
        border_on  = (col_x == 11'd0) || (col_x == ACT_COLS - 11'd1) ||
                     (row_x == 11'd0) || (row_x == ACT_ROWS - 11'd1);
        move_start = {1'b0, bar_pos_eff};
        move_end   = move_start + MOVE_W;
        move_on    = (col_x >= move_start) && (col_x < move_end);
    end

    // Pattern multiplexer; everything outside the visible area is forced to black.
    always_comb begin
        red_next = '0;
        grn_next = '0;
        blu_next = '0;
        if (active) begin
            case (pattern_eff)
                3'd0: begin
                    red_next = '0;
                    grn_next = '0;
                    blu_next = '0;
                end
                3'd1: begin
                    red_next = '1;
                    grn_next = '1;
                    blu_next = '1;
                end
                3'd2: begin
                    red_next = {c_VIDEO_WIDTH{bar_rgb[2]}};
                    grn_next = {c_VIDEO_WIDTH{bar_rgb[1]}};
                    blu_next = {c_VIDEO_WIDTH{bar_rgb[0]}};
                end
                3'd3: begin
                    red_next = {c_VIDEO_WIDTH{checker_on}};
                    grn_next = {c_VIDEO_WIDTH{checker_on}};
                    blu_next = {c_VIDEO_WIDTH{checker_on}};
                end
                3'd4: begin
                    red_next = {c_VIDEO_WIDTH{border_on}};
                    grn_next = {c_VIDEO_WIDTH{border_on}};
                    blu_next = {c_VIDEO_WIDTH{border_on}};
                end
                3'd5: begin
                    red_next = {c_VIDEO_WIDTH{move_on}};
                    grn_next = {c_VIDEO_WIDTH{move_on}};
                    blu_next = {c_VIDEO_WIDTH{move_on}};
                end
                3'd6: begin
                    red_next = c_VIDEO_WIDTH'(bar_idx);
                    grn_next = c_VIDEO_WIDTH'(i_Row_Count[8:6]);
                    blu_next = '0;
                end
                3'd7: begin
                    red_next = {c_VIDEO_WIDTH{frame_cnt_eff[7]}};
                    grn_next = {c_VIDEO_WIDTH{frame_cnt_eff[6]}};
                    blu_next = {c_VIDEO_WIDTH{frame_cnt_eff[5]}};
                end
            endcase
        end
    end

    // Output register: video, delayed counts and frame-start pulse stay aligned.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
            o_Col_Count   <= 10'd0;
            o_Row_Count   <= 10'd0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Red_Video   <= red_next;
            o_Grn_Video   <= grn_next;
            o_Blu_Video   <= blu_next;
            o_Col_Count   <= i_Col_Count;
            o_Row_Count   <= i_Row_Count;
            o_Frame_Start <= frame_start;
        end
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Registered VGA test-pattern source. Sits directly upstream of the sync/porch stage, which it feeds.
- Consumes the free-running column/row counts from the VGA counter.
- Produces 3-channel video, selected from 8 patterns. Two patterns are animated.
- Pattern changes take effect only at frame boundaries, so the screen never tears.

Parameters:
- c_VIDEO_WIDTH, 3, bits per colour channel
- c_ACTIVE_COLS, 640, visible columns
- c_ACTIVE_ROWS, 480, visible rows
- c_BAR_WIDTH, 80, colour-bar width in pixels (8 bars)
- c_CHECK_BIT, 5, count bit selecting checker size (2^5 = 32 px)
- c_MOVE_WIDTH, 16, moving-bar width in pixels
- c_MOVE_STEP, 4, moving-bar advance per frame in pixels

Ports:
- i_Clk, input, 1, pixel clock
- i_Rst_L, input, 1, asynchronous active-low reset
- i_Col_Count, input, 10, current column, 0..799
- i_Row_Count, input, 10, current row, 0..524
- i_Pattern_Sel, input, 3, pattern request (switches; asynchronous to i_Clk)
- o_Red_Video, output, c_VIDEO_WIDTH, red pixel
- o_Grn_Video, output, c_VIDEO_WIDTH, green pixel
- o_Blu_Video, output, c_VIDEO_WIDTH, blue pixel
- o_Col_Count, output, 10, i_Col_Count delayed 1 cycle (aligned with video)
- o_Row_Count, output, 10, i_Row_Count delayed 1 cycle
- o_Frame_Start, output, 1, 1-cycle pulse aligned with pixel (0,0) on the outputs

Behaviour:
- Reset (async, i_Rst_L=0): all outputs 0, active pattern 0, frame counter 0, bar position 0, synchroniser flops 0.
- i_Pattern_Sel passes through a 2-flop synchroniser.
- Frame start: i_Col_Count==0 && i_Row_Count==0. In that cycle:
  - synchronised select is latched as the active pattern;
  - 8-bit frame counter increments, wrapping 255->0;
  - bar position updates: pos+c_MOVE_STEP, minus c_ACTIVE_COLS if the sum is >= c_ACTIVE_COLS.
  - The new pattern/position/count apply to this same pixel onward.
- Latency: exactly 1 clock. Video, delayed counts and o_Frame_Start are all registered together.
- Blanking: col >= c_ACTIVE_COLS or row >= c_ACTIVE_ROWS -> all channels 0, whatever the pattern.
- "Full" means all bits 1; "on/off" per channel means full/0.
- Patterns (active area):
  - 0: black.
  - 1: white.
  - 2: colour bars. Bar index b = number of thresholds k*c_BAR_WIDTH (k=1..7) with col >= threshold; comparator chain, no divider. RGB per b=0..7: 111, 110, 011, 010, 101, 100, 001, 000 (white, yellow, cyan, green, magenta, red, blue, black).
  - 3: checkerboard. White if col[c_CHECK_BIT] XOR row[c_CHECK_BIT], else black.
  - 4: border. White if col==0, col==c_ACTIVE_COLS-1, row==0 or row==c_ACTIVE_ROWS-1; else black.
  - 5: moving bar. White if pos <= col < pos+c_MOVE_WIDTH; else black. Bar is clipped at the right edge, not wrapped onto the left.
  - 6: gradient. Red = b (same bar index as pattern 2), green = row[8:6] of the 10-bit count, blue 0.
  - 7: colour cycle. Whole active area is one colour: R/G/B on/off per frame_cnt[7]/[6]/[5].
- Mid-frame select change: current frame is unaffected; the change appears from the next frame start, subject to the 2-cycle synchroniser delay.
- Reset mid-frame: outputs go to 0 immediately. After release, pattern 0 is shown until the next frame start latches the select.
- Counts beyond the nominal totals: no special handling; the blanking rule covers them.

Test Plan:
- Reset: hold i_Rst_L=0 for 5 cycles with sel=3'd2 -> all outputs 0. After release, first frame is black; from the next (0,0) onward, col 0 and col 639 on row 0 are RGB 111, 111 and 000, 000.
- Colour bars: sel=2, scan a full frame -> at col 79 RGB=111, col 80 =110, col 559 =001, col 560 =000. Col 640..799 and rows 480..524 are 0. Output lags input by exactly 1 cycle.
- Checkerboard/border: sel=3 -> (0,0) black, (32,0) white, (32,32) black. Then sel=4 -> (0,100) white, (639,100) white, (1,1) black, (100,479) white.
- Mid-frame switch: sel 1->0 at row 200 -> rows 200..479 stay white. Next frame is fully black. o_Frame_Start pulses once per 800x525 cycles.
- Moving bar wrap: sel=5, run 160 frames -> pos 0,4,...,636 then 0. At pos=636, cols 636..639 are white and col 0 is black.
- Colour cycle: sel=7 -> after 32 frame starts frame_cnt=32, screen is blue (001). After 256 frame starts it wraps to 0 (black).
